puf_eval_sequencer: RTL and testbench

PUF_EVAL_SEQUENCER -- requirements
Module: puf_eval_sequencer

---
 rtl/puf_seq_pkg.sv | 16 +
 rtl/puf_vote_counter.sv | 42 ++++
 rtl/puf_eval_sequencer.sv | 135 +++++++++++++
 tb/tb_puf_eval_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_seq_pkg.sv
// Shared types and default sizing for the PUF evaluation sequencer.
package puf_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int DEF_CHAL_W    = 32;
    localparam int DEF_RESP_W    = 32;
    localparam int DEF_NUM_EVALS = 5;
    localparam int DEF_TIMEOUT   = 1024;

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit vote counters with majority decision over NUM_EVALS evaluations.
// The majority output includes the response being added this cycle.
module puf_vote_counter
    import puf_seq_pkg::*;
#(
    parameter int RESP_W    = DEF_RESP_W,
    parameter int NUM_EVALS = DEF_NUM_EVALS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_add,
    input  logic [RESP_W-1:0] i_bits,
    output logic [RESP_W-1:0] o_majority
);

    localparam int               CNT_W  = $clog2(NUM_EVALS + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(NUM_EVALS / 2);

    logic [CNT_W-1:0] r_cnt      [RESP_W];
    logic [CNT_W-1:0] w_cnt_next [RESP_W];

    always_comb begin
        for (int i = 0; i < RESP_W; i++) begin
            w_cnt_next[i] = r_cnt[i] + CNT_W'(i_bits[i]);
            o_majority[i] = (i_add ? w_cnt_next[i] : r_cnt[i]) > THRESH;
        end
    end

    // NOTE: these counters are individual flops, not a RAM, so they take the async reset;
    // non-blocking assignments keep every counter updating from the same pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < RESP_W; i++) r_cnt[i] <= '0;
        end else if (i_add) begin
            for (int i = 0; i < RESP_W; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

endmodule

// File: rtl/puf_eval_sequencer.sv
// Runs NUM_EVALS PUF evaluations per challenge and returns the bitwise majority,
// or an error response if the PUF core fails to answer within TIMEOUT cycles.
module puf_eval_sequencer
    import puf_seq_pkg::*;
#(
    parameter int CHAL_W    = DEF_CHAL_W,
    parameter int RESP_W    = DEF_RESP_W,
    parameter int NUM_EVALS = DEF_NUM_EVALS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CHAL_W-1:0] req_challenge,
    output logic              puf_start,
    output logic [CHAL_W-1:0] puf_challenge,
    input  logic              puf_done,
    input  logic [RESP_W-1:0] puf_response,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESP_W-1:0] resp_data,
    output logic              resp_error,
    output logic              busy
);

    localparam int EVAL_W = $clog2(NUM_EVALS + 1);
    localparam int TMO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t            r_state;
    state_t            w_state_next;
    logic [CHAL_W-1:0] r_challenge;
    logic [EVAL_W-1:0] r_eval_cnt;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic              r_puf_start;
    logic [RESP_W-1:0] r_resp_data;
    logic              r_resp_error;
    logic              w_accept;
    logic              w_sample;
    logic              w_last_eval;
    logic              w_timeout;
    logic [RESP_W-1:0] w_majority;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_sample     = 1'b0;
        w_last_eval  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: w_state_next = S_WAIT;
            S_WAIT: begin
                // A done arriving on the timeout cycle still counts as a good evaluation.
                if (puf_done) begin
                    w_sample     = 1'b1;
                    w_last_eval  = (r_eval_cnt == EVAL_W'(NUM_EVALS - 1));
                    w_state_next = w_last_eval ? S_RESP : S_LAUNCH;
                end else if (r_tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    w_timeout    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state      <= S_IDLE;
            r_challenge  <= '0;
            r_eval_cnt   <= '0;
            r_tmo_cnt    <= '0;
            r_puf_start  <= 1'b0;
            r_resp_data  <= '0;
            r_resp_error <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_puf_start <= (r_state == S_LAUNCH);

            if (w_accept) begin
                r_challenge  <= req_challenge;
                r_eval_cnt   <= '0;
                r_resp_data  <= '0;
                r_resp_error <= 1'b0;
            end else if (w_sample) begin
                r_eval_cnt <= r_eval_cnt + EVAL_W'(1);
            end

            if (r_state == S_LAUNCH) begin
                r_tmo_cnt <= '0;
            end else if (r_state == S_WAIT) begin
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            end

            if (w_sample && w_last_eval) begin
                r_resp_data  <= w_majority;
                r_resp_error <= 1'b0;
            end else if (w_timeout) begin
                r_resp_data  <= '0;
                r_resp_error <= 1'b1;
            end
        end
    end

    puf_vote_counter #(
        .RESP_W    (RESP_W),
        .NUM_EVALS (NUM_EVALS)
    ) u_vote (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_clear    (w_accept),
        .i_add      (w_sample),
        .i_bits     (puf_response),
        .o_majority (w_majority)
    );

    assign req_ready     = (r_state == S_IDLE) && !ARESET;
    assign puf_start     = r_puf_start;
    assign puf_challenge = r_challenge;
    assign resp_valid    = (r_state == S_RESP);
    assign resp_data     = r_resp_data;
    assign resp_error    = r_resp_error;
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed plus randomized bench for puf_eval_sequencer with a delay-configurable PUF model
// and a majority-vote reference computed from the response table.
module tb_puf_eval_sequencer;

    localparam int TB_CHAL_W  = 32;
    localparam int TB_RESP_W  = 32;
    localparam int TB_EVALS   = 5;
    localparam int TB_TIMEOUT = 16;

    logic                 ACLK;
    logic                 ARESET;
    logic                 req_valid;
    logic                 req_ready;
    logic [TB_CHAL_W-1:0] req_challenge;
    logic                 puf_start;
    logic [TB_CHAL_W-1:0] puf_challenge;
    logic                 puf_done;
    logic [TB_RESP_W-1:0] puf_response;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [TB_RESP_W-1:0] resp_data;
    logic                 resp_error;
    logic                 busy;

    int n_vec = 0;
    int n_err = 0;

    // PUF model controls: written by the stimulus block, read by the model
    logic [31:0] resp_tab [16];
    int          puf_delay  = 3;
    bit          puf_mute   = 1'b0;
    int          start_base = 0;
    int          spur_cnt   = 0;
    // PUF model state: written by the model only
    int          start_total = 0;
    int          spur_seen   = 0;

    puf_eval_sequencer #(
        .CHAL_W    (TB_CHAL_W),
        .RESP_W    (TB_RESP_W),
        .NUM_EVALS (TB_EVALS),
        .TIMEOUT   (TB_TIMEOUT)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_challenge (req_challenge),
        .puf_start     (puf_start),
        .puf_challenge (puf_challenge),
        .puf_done      (puf_done),
        .puf_response  (puf_response),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_error    (resp_error),
        .busy          (busy)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // PUF core model: done pulses puf_delay cycles after the cycle in which puf_start is high.
    initial begin
        int          countdown;
        logic [31:0] pend;
        countdown    = 0;
        pend         = '0;
        puf_done     = 1'b0;
        puf_response = '0;
        forever begin
            @(negedge ACLK);
            puf_done     = 1'b0;
            puf_response = '0;
            if (ARESET) begin
                countdown = 0;
            end else if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    puf_done     = 1'b1;
                    puf_response = pend;
                end
            end else if (spur_seen != spur_cnt) begin
                spur_seen    = spur_cnt;
                puf_done     = 1'b1;
                puf_response = '1;
            end
            if (!ARESET && puf_start === 1'b1) begin
                int idx;
                idx = start_total - start_base;
                start_total++;
                if (!puf_mute) begin
                    countdown = puf_delay;
                    pend      = resp_tab[idx % 16];
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no completion, required completion before time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bitwise majority over the first n entries of the response table.
    function automatic logic [31:0] vote(input int n);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            int ones;
            ones = 0;
            for (int e = 0; e < n; e++) ones += int'(resp_tab[e][b]);
            r[b] = (ones > n / 2);
        end
        return r;
    endfunction

    task automatic run_request(input string tag, input logic [31:0] chal, input int d,
                               input bit mute, input int hold, input bit poke);
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        int          exp_starts;
        int          lat;
        bit          chal_ok;
        bit          stable_ok;
        logic [31:0] data0;
        logic        err0;

        puf_delay  = d;
        puf_mute   = mute;
        exp_data   = mute ? 32'h0 : vote(TB_EVALS);
        exp_err    = mute;
        exp_lat    = mute ? 2 + TB_TIMEOUT : 1 + TB_EVALS * (2 + d);
        exp_starts = mute ? 1 : TB_EVALS;
        start_base = start_total;

        @(negedge ACLK);
        check({tag, ".req_ready"}, 32'(req_ready), 32'h1);
        req_valid     = 1'b1;
        req_challenge = chal;
        @(negedge ACLK);
        req_valid     = 1'b0;
        req_challenge = ~chal;
        lat     = 1;
        chal_ok = 1'b1;
        while (resp_valid !== 1'b1 && lat < 1000) begin
            if (puf_challenge !== chal) chal_ok = 1'b0;
            @(negedge ACLK);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".resp_data"}, resp_data, exp_data);
        check({tag, ".resp_error"}, 32'(resp_error), 32'(exp_err));
        check({tag, ".puf_starts"}, 32'(start_total - start_base), 32'(exp_starts));

        stable_ok = 1'b1;
        data0     = resp_data;
        err0      = resp_error;
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid     = 1'b1;
                req_challenge = 32'hDEAD_BEEF;
            end
            @(negedge ACLK);
            if (resp_valid !== 1'b1 || resp_data !== data0 || resp_error !== err0 ||
                req_ready !== 1'b0) stable_ok = 1'b0;
            if (puf_challenge !== chal) chal_ok = 1'b0;
        end
        check({tag, ".hold_stable"}, 32'(stable_ok), 32'h1);

        resp_ready = 1'b1;
        @(negedge ACLK);
        resp_ready = 1'b0;
        check({tag, ".chal_stable"}, 32'(chal_ok), 32'h1);
        check({tag, ".resp_valid_drop"}, 32'(resp_valid), 32'h0);
        check({tag, ".idle_after"}, 32'(busy), 32'h0);
        check({tag, ".starts_after"}, 32'(start_total - start_base), 32'(exp_starts));
        req_valid     = 1'b0;
        req_challenge = '0;
    endtask

    initial begin
        int  guard;
        bit  no_resp;

        ARESET        = 1'b1;
        req_valid     = 1'b0;
        req_challenge = '0;
        resp_ready    = 1'b0;
        for (int i = 0; i < 16; i++) resp_tab[i] = '0;

        // Reset state
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("rst.req_ready", 32'(req_ready), 32'h1);
        check("rst.busy", 32'(busy), 32'h0);
        check("rst.resp_valid", 32'(resp_valid), 32'h0);
        check("rst.puf_start", 32'(puf_start), 32'h0);
        check("rst.puf_challenge", puf_challenge, 32'h0);
        check("rst.resp_data", resp_data, 32'h0);
        check("rst.resp_error", 32'(resp_error), 32'h0);

        // Consistent response, D=3
        for (int i = 0; i < TB_EVALS; i++) resp_tab[i] = 32'hA5A5_A5A5;
        run_request("a5", 32'hC0FF_EE01, 3, 1'b0, 0, 1'b0);

        // Majority vote on low byte
        resp_tab[0] = 32'hFF; resp_tab[1] = 32'hFF; resp_tab[2] = 32'hFF;
        resp_tab[3] = 32'h00; resp_tab[4] = 32'h00;
        run_request("maj3of5", 32'h0000_0011, 2, 1'b0, 1, 1'b0);
        check("maj3of5.model", vote(TB_EVALS), 32'h0000_00FF);
        resp_tab[0] = 32'hFF; resp_tab[1] = 32'h00; resp_tab[2] = 32'h00;
        resp_tab[3] = 32'hFF; resp_tab[4] = 32'h00;
        run_request("maj2of5", 32'h0000_0022, 1, 1'b0, 0, 1'b0);

        // PUF never answers
        run_request("timeout", 32'h5555_AAAA, 3, 1'b1, 2, 1'b0);

        // Done on the very cycle the timeout would fire
        for (int i = 0; i < TB_EVALS; i++) resp_tab[i] = $urandom;
        run_request("done_at_tmo", 32'h0BAD_F00D, TB_TIMEOUT - 1, 1'b0, 0, 1'b0);

        // Consumer stalls 50 cycles while another request is offered
        for (int i = 0; i < TB_EVALS; i++) resp_tab[i] = $urandom;
        run_request("stall50", 32'h7777_0000, 2, 1'b0, 50, 1'b1);

        // Reset during the third evaluation
        for (int i = 0; i < TB_EVALS; i++) resp_tab[i] = 32'hFFFF_FFFF;
        puf_delay  = 4;
        puf_mute   = 1'b0;
        start_base = start_total;
        @(negedge ACLK);
        req_valid     = 1'b1;
        req_challenge = 32'hABCD_0123;
        @(negedge ACLK);
        req_valid = 1'b0;
        guard     = 0;
        while (start_total - start_base < 3 && guard < 500) begin
            @(negedge ACLK);
            guard++;
        end
        check("abort.third_start", 32'(start_total - start_base), 32'h3);
        repeat (2) @(negedge ACLK);
        check("abort.busy_before", 32'(busy), 32'h1);
        #2 ARESET = 1'b1;
        #1;
        check("abort.busy", 32'(busy), 32'h0);
        check("abort.puf_start", 32'(puf_start), 32'h0);
        check("abort.puf_challenge", puf_challenge, 32'h0);
        check("abort.resp_valid", 32'(resp_valid), 32'h0);
        @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        check("abort.req_ready", 32'(req_ready), 32'h1);
        no_resp = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge ACLK);
            if (resp_valid !== 1'b0 || busy !== 1'b0) no_resp = 1'b0;
        end
        check("abort.no_response", 32'(no_resp), 32'h1);
        resp_tab[0] = 32'h1234_5678; resp_tab[1] = 32'h1234_5678; resp_tab[2] = 32'h0000_0000;
        resp_tab[3] = 32'h1234_5678; resp_tab[4] = 32'hFFFF_FFFF;
        run_request("post_reset", 32'h1234_5678, 3, 1'b0, 0, 1'b0);

        // Randomized requests, each preceded by a stray done while idle
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < TB_EVALS; i++) resp_tab[i] = $urandom;
            spur_cnt++;
            repeat (3) @(negedge ACLK);
            run_request($sformatf("rand%0d", it), $urandom, int'($urandom_range(1, 6)),
                        1'b0, int'($urandom_range(0, 3)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
